// File: rtl/zeta_addr_sched_if.sv
// ---------------------------------------------------------------------------
// zeta_addr_sched_if
// Bundle between the polynomial input stream, the zeta address scheduler and
// the zeta_rom / butterfly array.
//   in_valid   : one beat (2 butterflies) of a polynomial enters stage 0
//   in_inv     : 0=NTT, 1=INTT, taken from the first beat of a polynomial
//   rom_addr   : zeta_rom address per [lane][stage]
//   addr_valid : rom_addr[*][s] is a live request this cycle
//   zeta_valid : zeta_rom data for stage s is valid this cycle
//   stage_inv  : mode of the polynomial currently in stage s
//   poly_done  : last beat of a polynomial issued at the final stage
// master = stream source side, slave = scheduler side.
// ---------------------------------------------------------------------------
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 8
`endif

interface zeta_addr_sched_if #(
    parameter int N = `NTT_STAGE_CNT
);
    logic         in_valid;
    logic         in_inv;
    logic [N-2:0] rom_addr [2][N];
    logic [N-1:0] addr_valid;
    logic [N-1:0] zeta_valid;
    logic [N-1:0] stage_inv;
    logic         poly_done;

    modport master (
        output in_valid, in_inv,
        input  rom_addr, addr_valid, zeta_valid, stage_inv, poly_done
    );

    modport slave (
        input  in_valid, in_inv,
        output rom_addr, addr_valid, zeta_valid, stage_inv, poly_done
    );
endinterface

// File: rtl/zeta_addr_sched.sv
// ---------------------------------------------------------------------------
// zeta_addr_sched
// Schedules twiddle (zeta) reads for the pipelined NTT/INTT datapath. Every
// beat entering stage 0 is followed through all N butterfly stages; at each
// stage a per-lane zeta_rom address is issued in step with the data, and a
// zeta_valid aligned with the registered ROM output is produced.
// Ports:
//   clk   : system clock
//   rst_n : synchronous reset, active low
//   bus   : zeta_addr_sched_if.slave (in_valid/in_inv in; rom_addr,
//           addr_valid, zeta_valid, stage_inv, poly_done out)
// Parameters:
//   STAGE_LAT : cycles between a beat entering stage s and stage s+1 (>=1)
//   ROM_LAT   : zeta_rom read latency (>=1)
// ---------------------------------------------------------------------------
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 8
`endif

module zeta_addr_sched #(
    parameter int STAGE_LAT = 2,
    parameter int ROM_LAT   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    zeta_addr_sched_if.slave   bus
);
    localparam int N   = `NTT_STAGE_CNT;
    localparam int CW  = N - 2;                  // beat counter width
    localparam int AW  = N - 1;                  // address width
    localparam int DLY = (N - 1) * STAGE_LAT;    // stage-0 input to last stage input

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};
    localparam logic [N-1:0]  ONE_N    = {{(N-1){1'b0}}, 1'b1};

    // Address of lane 'lane' for beat 'cnt' at stage 'stg'. The butterfly
    // index {cnt,lane} shifted down leaves the group number; INTT walks the
    // groups in reverse within the 2^stg entries used by that stage.
    function automatic logic [AW-1:0] zeta_addr(
        input logic [CW-1:0] cnt,
        input logic          lane,
        input int            stg,
        input logic          inv
    );
        logic [N-1:0] bfly;
        logic [N-1:0] grp;
        logic [N-1:0] top;
        logic [N-1:0] res;
        bfly = {1'b0, cnt, lane};
        grp  = bfly >> (N - 1 - stg);
        top  = (ONE_N << stg) - ONE_N;
        if (inv) begin
            res = top - grp;
        end else begin
            res = grp;
        end
        return res[AW-1:0];
    endfunction

    // Beat delay line from stage 0 input: valid plus the polynomial mode that
    // beat belongs to. Stage s taps it at s*STAGE_LAT.
    logic [DLY:1]  dly_v_r;
    logic [DLY:1]  dly_m_r;

    logic [CW-1:0]         cnt_r  [N];
    logic [1:0][AW-1:0]    addr_r [N];
    logic [N-1:0]          av_r;
    logic [N-1:0]          inv_r;
    logic [N-1:0]          zv_r   [ROM_LAT];
    logic                  done_r;

    logic [N-1:0]          stg_v_s;   // beat arriving at stage s this cycle
    logic [N-1:0]          stg_m_s;   // mode carried with that beat
    logic [N-1:0]          eff_m_s;   // mode to use for the beat at stage s

    // Stage input taps and the effective mode: beat 0 takes the incoming
    // mode, later beats keep the one latched on beat 0.
    always_comb begin
        stg_v_s    = '0;
        stg_m_s    = '0;
        eff_m_s    = '0;
        stg_v_s[0] = bus.in_valid;
        stg_m_s[0] = bus.in_inv;
        for (int s = 1; s < N; s++) begin
            stg_v_s[s] = dly_v_r[s*STAGE_LAT];
            stg_m_s[s] = dly_m_r[s*STAGE_LAT];
        end
        for (int s = 0; s < N; s++) begin
            if (cnt_r[s] == CNT_ZERO) begin
                eff_m_s[s] = stg_m_s[s];
            end else begin
                eff_m_s[s] = inv_r[s];
            end
        end
    end

    // Delay line, per-stage counters/addresses/modes, done pulse, ROM pipe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dly_v_r <= '0;
            dly_m_r <= '0;
            av_r    <= '0;
            inv_r   <= '0;
            done_r  <= 1'b0;
            for (int s = 0; s < N; s++) begin
                cnt_r[s]  <= CNT_ZERO;
                addr_r[s] <= '0;
            end
            for (int k = 0; k < ROM_LAT; k++) begin
                zv_r[k] <= '0;
            end
        end else begin
            dly_v_r[1] <= stg_v_s[0];
            dly_m_r[1] <= eff_m_s[0];
            for (int k = 2; k <= DLY; k++) begin
                dly_v_r[k] <= dly_v_r[k-1];
                dly_m_r[k] <= dly_m_r[k-1];
            end
            av_r <= stg_v_s;
            for (int s = 0; s < N; s++) begin
                if (stg_v_s[s]) begin
                    cnt_r[s]     <= cnt_r[s] + CNT_ONE;   // wraps at polynomial boundary
                    inv_r[s]     <= eff_m_s[s];
                    addr_r[s][0] <= zeta_addr(cnt_r[s], 1'b0, s, eff_m_s[s]);
                    addr_r[s][1] <= zeta_addr(cnt_r[s], 1'b1, s, eff_m_s[s]);
                end
            end
            done_r  <= stg_v_s[N-1] && (cnt_r[N-1] == CNT_LAST);
            zv_r[0] <= av_r;
            for (int k = 1; k < ROM_LAT; k++) begin
                zv_r[k] <= zv_r[k-1];
            end
        end
    end

    assign bus.addr_valid = av_r;
    assign bus.zeta_valid = zv_r[ROM_LAT-1];
    assign bus.stage_inv  = inv_r;
    assign bus.poly_done  = done_r;

    for (genvar gs = 0; gs < N; gs++) begin : g_stage
        for (genvar gl = 0; gl < 2; gl++) begin : g_lane
            assign bus.rom_addr[gl][gs] = addr_r[gs][gl];
        end
    end
endmodule

// File: tb/tb_zeta_addr_sched.sv
module tb_zeta_addr_sched;
    localparam int N     = 8;
    localparam int SL    = 2;
    localparam int RL    = 1;
    localparam int BEATS = 64;
    localparam int LEN   = 520;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    zeta_addr_sched_if #(.N(N)) bus();

    zeta_addr_sched #(.STAGE_LAT(SL), .ROM_LAT(RL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Expected zeta address: group = butterfly / groupsize, reversed for INTT.
    function automatic int ref_addr(input int beat, input int lane, input int s, input logic inv);
        int b;
        int g;
        b = 2 * beat + lane;
        g = b / (1 << (N - 1 - s));
        if (inv) return (1 << s) - 1 - g;
        return g;
    endfunction

    logic st_v [LEN];
    logic st_i [LEN];
    logic st_r [LEN];
    logic hv   [LEN];
    logic hm   [LEN];
    int   hb   [LEN];
    int   exp_addr [2][N];
    int   exp_inv  [N];

    initial begin
        int last_rst;
        int bcnt;
        logic cmode;
        int cyc;
        logic [N-1:0] e_av;
        logic [N-1:0] e_zv;
        int e_pd;

        for (int k = 0; k < LEN; k++) begin
            st_v[k] = 1'b0;
            st_i[k] = 1'b0;
            st_r[k] = 1'b0;
        end
        // 1: reset, single pulse
        st_r[0] = 1'b1;
        st_r[1] = 1'b1;
        st_v[4] = 1'b1;
        // 2/4: reset, NTT poly then INTT poly with no gap
        st_r[40] = 1'b1;
        for (int b = 0; b < BEATS; b++) st_v[42+b] = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            st_v[106+b] = 1'b1;
            st_i[106+b] = (b == 0) ? 1'b1 : ((b % 3) == 1) ? 1'b0 : 1'b1;
        end
        // 5: random bubbles
        for (int k = 172; k < 372; k++) begin
            st_v[k] = ($urandom_range(0, 1) == 1);
            st_i[k] = 1'b1;
        end
        // 6: reset, abort at beat 30, restart as INTT
        st_r[380] = 1'b1;
        for (int k = 382; k < 412; k++) st_v[k] = 1'b1;
        st_r[412] = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            st_v[413+b] = 1'b1;
            st_i[413+b] = 1'b1;
        end

        for (int s = 0; s < N; s++) begin
            exp_inv[s] = 0;
            exp_addr[0][s] = 0;
            exp_addr[1][s] = 0;
        end
        last_rst = -1;
        bcnt     = 0;
        cmode    = 1'b0;

        for (int k = 0; k < LEN - 1; k++) begin
            rst_n        = !st_r[k];
            bus.in_valid = st_v[k] && !st_r[k];
            bus.in_inv   = st_i[k];
            hv[k] = 1'b0;
            hm[k] = 1'b0;
            hb[k] = 0;
            if (st_r[k]) begin
                bcnt     = 0;
                cmode    = 1'b0;
                last_rst = k;
            end else if (st_v[k]) begin
                if (bcnt == 0) cmode = st_i[k];
                hv[k] = 1'b1;
                hm[k] = cmode;
                hb[k] = bcnt;
                bcnt  = (bcnt + 1) % BEATS;
            end
            @(posedge clk);
            #1;
            cyc = k + 1;
            if (st_r[k]) begin
                for (int s = 0; s < N; s++) begin
                    exp_inv[s] = 0;
                    exp_addr[0][s] = 0;
                    exp_addr[1][s] = 0;
                end
            end
            e_av = '0;
            e_zv = '0;
            e_pd = 0;
            for (int s = 0; s < N; s++) begin
                int i;
                int j;
                i = cyc - 1 - s * SL;
                j = i - RL;
                if (i > last_rst && i >= 0 && hv[i]) begin
                    e_av[s] = 1'b1;
                    exp_addr[0][s] = ref_addr(hb[i], 0, s, hm[i]);
                    exp_addr[1][s] = ref_addr(hb[i], 1, s, hm[i]);
                    if (hb[i] == 0) exp_inv[s] = int'(hm[i]);
                    if (s == N - 1 && hb[i] == BEATS - 1) e_pd = 1;
                end
                if (j > last_rst && j >= 0 && hv[j]) e_zv[s] = 1'b1;
            end
            chk($sformatf("addr_valid@%0d", cyc), int'(bus.addr_valid), int'(e_av));
            chk($sformatf("zeta_valid@%0d", cyc), int'(bus.zeta_valid), int'(e_zv));
            chk($sformatf("poly_done@%0d", cyc), int'(bus.poly_done), e_pd);
            for (int s = 0; s < N; s++) begin
                chk($sformatf("stage_inv[%0d]@%0d", s, cyc), int'(bus.stage_inv[s]), exp_inv[s]);
                chk($sformatf("rom_addr[0][%0d]@%0d", s, cyc), int'(bus.rom_addr[0][s]), exp_addr[0][s]);
                chk($sformatf("rom_addr[1][%0d]@%0d", s, cyc), int'(bus.rom_addr[1][s]), exp_addr[1][s]);
            end

            // Hand-computed spot values
            if (cyc == 5)  chk("t1_av0", int'(bus.addr_valid), 1);
            if (cyc == 11) chk("t1_av3", int'(bus.addr_valid), 8);
            if (cyc == 19) chk("t1_av7", int'(bus.addr_valid), 128);
            if (cyc == 20) begin
                chk("t1_zv7", int'(bus.zeta_valid), 128);
                chk("t1_av_off", int'(bus.addr_valid), 0);
            end
            if (cyc == 54) begin
                chk("t2_s3b5_l0", int'(bus.rom_addr[0][3]), 0);
                chk("t2_s3b5_l1", int'(bus.rom_addr[1][3]), 0);
            end
            if (cyc == 57) begin
                chk("t2_s3b8_l0", int'(bus.rom_addr[0][3]), 1);
                chk("t2_s3b8_l1", int'(bus.rom_addr[1][3]), 1);
            end
            if (cyc == 62) begin
                chk("t2_s7b5_l0", int'(bus.rom_addr[0][7]), 10);
                chk("t2_s7b5_l1", int'(bus.rom_addr[1][7]), 11);
            end
            if (cyc == 119) chk("t2_done_early", int'(bus.poly_done), 0);
            if (cyc == 120) begin
                chk("t2_done", int'(bus.poly_done), 1);
                chk("t4_inv7_ntt", int'(bus.stage_inv[7]), 0);
            end
            if (cyc == 121) begin
                chk("t3_s3b8_l0", int'(bus.rom_addr[0][3]), 6);
                chk("t3_s3b8_l1", int'(bus.rom_addr[1][3]), 6);
                chk("t3_s7b0_l0", int'(bus.rom_addr[0][7]), 127);
                chk("t3_s7b0_l1", int'(bus.rom_addr[1][7]), 126);
                chk("t4_inv7_intt", int'(bus.stage_inv[7]), 1);
            end
            if (cyc == 184) begin
                chk("t4_done2", int'(bus.poly_done), 1);
                chk("t3_inv_all", int'(bus.stage_inv), 255);
            end
            if (cyc == 413) begin
                chk("t6_av_cleared", int'(bus.addr_valid), 0);
                chk("t6_zv_cleared", int'(bus.zeta_valid), 0);
            end
            if (cyc == 414) begin
                chk("t6_restart_av", int'(bus.addr_valid), 1);
                chk("t6_restart_addr", int'(bus.rom_addr[0][0]), 0);
                chk("t6_restart_inv", int'(bus.stage_inv[0]), 1);
            end
            if (cyc == 428) begin
                chk("t6_s3b8_l0", int'(bus.rom_addr[0][3]), 6);
                chk("t6_s3b8_l1", int'(bus.rom_addr[1][3]), 6);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
